// File: rtl/add_slice_seq_pkg.sv
// rtl/add_slice_seq_pkg.sv - shared types and constants for the sliced adder sequencer
// Contents: SLICE_W (datapath slice width), add_seq_state_e (controller states).
package add_slice_seq_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_seq_state_e;

endpackage

// File: rtl/full_adder_16bit.sv
// rtl/full_adder_16bit.sv - 16-bit add/subtract slice with carry in/out
// Ports:
//   A, B      in  16 : operands
//   Invert_B  in  1  : complement B (subtraction when C_in starts at 1)
//   C_in      in  1  : carry in
//   Sum       out 16 : slice result
//   C_out     out 1  : carry out
module full_adder_16bit (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Invert_B,
    input  logic        C_in,
    output logic [15:0] Sum,
    output logic        C_out
);

    logic [15:0] b_eff;

    assign b_eff          = B ^ {16{Invert_B}};
    assign {C_out, Sum}   = {1'b0, A} + {1'b0, b_eff} + {16'd0, C_in};

endmodule

// File: rtl/add_slice_sequencer.sv
// rtl/add_slice_sequencer.sv - WIDTH-bit A+/-B computed one 16-bit slice per cycle
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   req_valid/req_ready    : request handshake; A, B, sub captured on accept
//   resp_valid/resp_ready  : response handshake; Sum, C_out, overflow held in DONE
// Optional build macro ADD_SLICE_SEQ_OVERFLOW_EN: registers signed overflow;
// without it the overflow port is tied to 0.
module add_slice_sequencer
    import add_slice_seq_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             C_out,
    output logic             overflow
);

    localparam int N     = WIDTH / SLICE_W;
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    add_seq_state_e    state;
    add_seq_state_e    state_next;
    logic              accept;
    logic [IDX_W-1:0]  idx;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              sub_reg;
    logic              carry_reg;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic              slice_cout;
    logic              last_step;

    assign slice_a   = a_reg[idx*SLICE_W +: SLICE_W];
    assign slice_b   = b_reg[idx*SLICE_W +: SLICE_W];
    assign last_step = (state == RUN) && (idx == LAST_IDX);

    full_adder_16bit u_slice (
        .A        (slice_a),
        .B        (slice_b),
        .Invert_B (sub_reg),
        .C_in     (carry_reg),
        .Sum      (slice_sum),
        .C_out    (slice_cout)
    );

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                // Draining the result frees the slot, so a waiting request
                // can be taken on the same edge with no idle bubble.
                if (resp_ready) begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        accept     = 1'b1;
                        state_next = RUN;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sub_reg   <= 1'b0;
            carry_reg <= 1'b0;
            idx       <= '0;
            Sum       <= '0;
            C_out     <= 1'b0;
        end else if (accept) begin
            a_reg     <= A;
            b_reg     <= B;
            sub_reg   <= sub;
            // Subtraction is A + ~B + 1: the +1 enters as the first carry.
            carry_reg <= sub;
            idx       <= '0;
        end else if (state == RUN) begin
            Sum[idx*SLICE_W +: SLICE_W] <= slice_sum;
            carry_reg                   <= slice_cout;
            if (idx == LAST_IDX) begin
                C_out <= slice_cout;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

`ifdef ADD_SLICE_SEQ_OVERFLOW_EN
    // Operands of effectively equal sign whose result sign differs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (last_step) begin
            overflow <= (a_reg[WIDTH-1] == (b_reg[WIDTH-1] ^ sub_reg)) &&
                        (slice_sum[SLICE_W-1] != a_reg[WIDTH-1]);
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_add_slice_sequencer.sv
// tb/tb_add_slice_sequencer.sv - scoreboard bench for add_slice_sequencer
module tb_add_slice_sequencer;

    localparam int W = 64;
    localparam int N = W / 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         sub = 1'b0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [W-1:0] Sum;
    logic         C_out;
    logic         overflow;

    add_slice_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .A          (A),
        .B          (B),
        .sub        (sub),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .Sum        (Sum),
        .C_out      (C_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           rise;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   rr_mode = 0;
    logic mon_prev = 1'b0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: unsigned arithmetic for sum/carry, sign-extended arithmetic
    // for overflow.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t       e;
        logic [W:0] full;
        logic [W:0] ext;
        if (!s) begin
            full   = {1'b0, a} + {1'b0, b};
            e.sum  = full[W-1:0];
            e.cout = full[W];
            ext    = {a[W-1], a} + {b[W-1], b};
        end else begin
            e.sum  = a - b;
            e.cout = (a >= b);
            ext    = {a[W-1], a} - {b[W-1], b};
        end
`ifdef ADD_SLICE_SEQ_OVERFLOW_EN
        e.ovf = ext[W] ^ ext[W-1];
`else
        e.ovf = 1'b0;
`endif
        e.rise = 0;
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b0, {(W-1){1'b1}}};
            3:       v = {1'b1, {(W-1){1'b0}}};
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        case (rr_mode)
            0:       resp_ready = 1'b1;
            1:       resp_ready = ($urandom_range(0, 3) != 0);
            default: resp_ready = 1'b0;
        endcase
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        A = a;
        B = b;
        sub = s;
        req_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin
                e = model(a, b, s);
                e.rise = cyc + 1 + N;
                sb.push_back(e);
                tick();
                req_valid = 1'b0;
                A = {$urandom, $urandom};
                B = {$urandom, $urandom};
                return;
            end
            tick();
        end
        check("accept_timeout", 64'd0, 64'd1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check("drain", sb.size(), 64'd0);
    endtask

    // Monitor: compares every presented result against the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_prev = 1'b0;
            end else begin
                if (resp_valid) begin
                    if (sb.size() == 0) begin
                        check("resp_unexpected", 64'd1, 64'd0);
                    end else begin
                        if (!mon_prev) check("resp_latency", cyc, sb[0].rise);
                        check("sum", Sum, sb[0].sum);
                        check("c_out", C_out, sb[0].cout);
                        check("overflow", overflow, sb[0].ovf);
                        if (resp_ready) void'(sb.pop_front());
                    end
                end
                mon_prev = resp_valid;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bit got_done;
        #2;
        check("rst_resp_valid", resp_valid, 64'd0);
        check("rst_sum", Sum, 64'd0);
        check("rst_c_out", C_out, 64'd0);
        check("rst_overflow", overflow, 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", req_ready, 64'd1);
        @(posedge clk);
        #1;

        rr_mode = 0;
        resp_ready = 1'b1;
        issue(64'h0000_0000_0000_FFFF, 64'd1, 1'b0);
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        issue(64'd5, 64'd7, 1'b1);
        issue(64'd7, 64'd5, 1'b1);
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        drain();

        // Hold the result in DONE, then release it with a request waiting.
        rr_mode = 2;
        resp_ready = 1'b0;
        issue(64'd100, 64'd23, 1'b0);
        got_done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                got_done = 1'b1;
                break;
            end
        end
        check("done_reached", got_done, 64'd1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            check("hold_req_ready", req_ready, 64'd0);
            check("hold_resp_valid", resp_valid, 64'd1);
        end
        @(posedge clk);
        #1;
        rr_mode = 0;
        resp_ready = 1'b1;
        issue(64'd2, 64'd3, 1'b0);
        drain();

        // Reset in the middle of a computation.
        issue(64'd1, 64'd2, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("abort_resp_valid", resp_valid, 64'd0);
        check("abort_sum", Sum, 64'd0);
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", req_ready, 64'd1);
        check("post_rst_resp_valid", resp_valid, 64'd0);
        @(posedge clk);
        #1;
        issue(64'h0000_1234_0000_5678, 64'h0000_4321_0000_8765, 1'b1);
        drain();

        rr_mode = 1;
        for (int n = 0; n < 150; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            issue(rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)));
        end
        rr_mode = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
